// File: rtl/simd_pico_pkg.sv
// Shared types and constants for the Pico-bus SIMD co-processor.
// Optional feature macro: SIMD_SAT_EN (saturating multiply-accumulate).
package simd_pico_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'd0,
    MODE_MUL = 2'd1,
    MODE_MAC = 2'd2,
    MODE_NOP = 2'd3
  } mode_t;

  localparam int B_BASE    = 32;
  localparam int MODE_ADDR = 64;
  localparam int MAX_LANES = 32;

  // Bus lines that travel through the synchroniser alongside the strobes,
  // so the write data and qualifiers line up with the detected edge.
  typedef struct packed {
    logic       cs;
    logic       cd;
    logic       sel_poc;
    logic [7:0] pico;
    logic [7:0] cam;
  } bus_sample_t;

  // Write-source multiplexer: host bus or camera pixel.
  function automatic logic [7:0] write_byte(bus_sample_t s);
    return s.sel_poc ? s.cam : s.pico;
  endfunction

endpackage

// File: rtl/simd_pico_if.sv
// Pico host-side control bundle. The bidirectional pico_data bus stays a
// plain inout on the top so the tri-state pad is visible at the boundary.
interface simd_pico_if;
  logic       CS;
  logic       WR;
  logic       RD;
  logic       CD;
  logic       excute;
  logic       sel_poc;
  logic       sel_sod;
  logic       direction;
  logic [7:0] cam_data;
  logic [7:0] LCD_data;

  modport master (
    output CS, WR, RD, CD, excute, sel_poc, sel_sod, direction, cam_data,
    input  LCD_data
  );

  modport slave (
    input  CS, WR, RD, CD, excute, sel_poc, sel_sod, direction, cam_data,
    output LCD_data
  );
endinterface

// File: rtl/simd_lane.sv
// One combinational SIMD lane: add, multiply, multiply-accumulate or hold.
// With SIMD_SAT_EN defined the accumulate clamps at 16'hFFFF.
module simd_lane
  import simd_pico_pkg::*;
(
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [15:0] acc,
  input  mode_t       mode,
  output logic [15:0] r
);

  logic [15:0] prod;
  logic [15:0] mac_r;

  assign prod = {8'h00, a} * {8'h00, b};

`ifdef SIMD_SAT_EN
  logic [16:0] mac_sum;
  assign mac_sum = {1'b0, prod} + {1'b0, acc};
  assign mac_r   = mac_sum[16] ? 16'hFFFF : mac_sum[15:0];
`else
  assign mac_r   = prod + acc;
`endif

  // Select the lane result for the active mode; NOP keeps the old value.
  always_comb begin
    case (mode)
      MODE_ADD: r = {8'h00, a} + {8'h00, b};
      MODE_MUL: r = prod;
      MODE_MAC: r = mac_r;
      default:  r = acc;
    endcase
  end

endmodule

// File: rtl/simd_pico_top.sv
// Pico-bus SIMD co-processor: operand banks A/B, mode register, LANES
// parallel lanes into a 16-bit result bank, byte-wise readback to host/LCD.
// Optional feature macro: SIMD_SAT_EN (passed down to simd_lane).
module simd_pico_top #(
  parameter int LANES     = 32,
  parameter int B_BASE    = simd_pico_pkg::B_BASE,
  parameter int MODE_ADDR = simd_pico_pkg::MODE_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  simd_pico_if.slave  bus,
  inout  wire  [7:0]  pico_data
);
  import simd_pico_pkg::*;

  localparam logic [5:0] LAST_BYTE = 6'(2 * LANES - 1);

  // Synchroniser stages: [0] and [1] are the 2-flop synchroniser, [2] is
  // the delayed copy used by the edge detector.
  logic [2:0]  wr_sync_q, rd_sync_q, ex_sync_q;
  bus_sample_t samp_in, samp_s1_q, samp_s2_q;

  logic        wr_evt, rd_evt, ex_evt;
  logic [7:0]  wdata;

  logic [7:0]  a_q [LANES];
  logic [7:0]  a_d [LANES];
  logic [7:0]  b_q [LANES];
  logic [7:0]  b_d [LANES];
  logic [15:0] r_q [LANES];
  logic [15:0] lane_r [LANES];
  mode_t       mode_q, mode_d;
  logic [6:0]  addr_q, addr_d;
  logic [5:0]  rd_ptr_q, rd_ptr_d;

  logic [15:0] rd_word;
  logic [7:0]  rbyte;

  assign samp_in = '{cs: bus.CS, cd: bus.CD, sel_poc: bus.sel_poc,
                     pico: pico_data, cam: bus.cam_data};

  // Bring the asynchronous strobes and their data into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sync_q <= '0;
      rd_sync_q <= '1;  // RD idles high
      ex_sync_q <= '0;
      samp_s1_q <= '0;
      samp_s2_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the value
      // from before this edge; blocking ones would collapse the chain.
      wr_sync_q <= {wr_sync_q[1:0], bus.WR};
      rd_sync_q <= {rd_sync_q[1:0], bus.RD};
      ex_sync_q <= {ex_sync_q[1:0], bus.excute};
      samp_s1_q <= samp_in;
      samp_s2_q <= samp_s1_q;
    end
  end

  assign wr_evt = wr_sync_q[1] & ~wr_sync_q[2] & samp_s2_q.cs;
  assign rd_evt = ~rd_sync_q[1] & rd_sync_q[2] & samp_s2_q.cs;
  assign ex_evt = ex_sync_q[1] & ~ex_sync_q[2];
  assign wdata  = write_byte(samp_s2_q);

  // Decode a host write into next-state operand, mode and address values.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    a_d    = a_q;
    b_d    = b_q;
    mode_d = mode_q;
    addr_d = addr_q;
    if (wr_evt) begin
      if (samp_s2_q.cd) begin
        addr_d = wdata[6:0];
      end else begin
        for (int i = 0; i < LANES; i++) begin
          if (addr_q == 7'(i))          a_d[i] = wdata;
          if (addr_q == 7'(B_BASE + i)) b_d[i] = wdata;
        end
        if (addr_q == 7'(MODE_ADDR)) mode_d = mode_t'(wdata[1:0]);
      end
    end
  end

  // Lanes see the post-write operands, so a same-cycle write is honoured.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    simd_lane u_lane (
      .a    (a_d[i]),
      .b    (b_d[i]),
      .acc  (r_q[i]),
      .mode (mode_d),
      .r    (lane_r[i])
    );
  end

  // Read pointer: execute clears it, an address write clears it, RD steps it.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (ex_evt || (wr_evt && samp_s2_q.cd)) begin
      rd_ptr_d = '0;
    end else if (rd_evt) begin
      rd_ptr_d = (rd_ptr_q == LAST_BYTE) ? 6'd0 : rd_ptr_q + 6'd1;
    end
  end

  // Architectural state: banks, mode, address and read pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the banks must read back as zero after reset, so they are
      // cleared here rather than left as uninitialised storage.
      a_q      <= '{default: '0};
      b_q      <= '{default: '0};
      r_q      <= '{default: '0};
      mode_q   <= MODE_ADD;
      addr_q   <= '0;
      rd_ptr_q <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      addr_q   <= addr_d;
      rd_ptr_q <= rd_ptr_d;
      if (ex_evt) r_q <= lane_r;
    end
  end

  // Result byte selection: low byte of each word first.
  always_comb begin
    rd_word = r_q[rd_ptr_q[5:1]];
    rbyte   = rd_ptr_q[0] ? rd_word[15:8] : rd_word[7:0];
  end

  assign bus.LCD_data = bus.sel_sod ? 8'h00 : rbyte;
  assign pico_data    = (bus.CS & bus.direction & bus.sel_sod) ? rbyte : 8'hzz;

endmodule

// File: tb/tb_simd_pico_top.sv
// Directed, table-driven bench for simd_pico_top. Undriven pico_data is
// pulled up, so a released bus reads back as 8'hFF.
module tb_simd_pico_top;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  simd_pico_if bus ();
  wire  [7:0] pico_data;
  logic       drv_en  = 1'b0;
  logic [7:0] drv_val = 8'h00;

  assign pico_data = drv_en ? drv_val : 8'hzz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (pico_data[i]);
  end

  simd_pico_top dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .pico_data (pico_data)
  );

  typedef enum {T_WA, T_WD, T_EX, T_RD} vop_t;
  typedef struct {
    vop_t       op;
    logic [7:0] val;   // write byte, or expected read byte for T_RD
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;

  function automatic void add(vop_t o, logic [7:0] v);
    vecs.push_back('{o, v});
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    else passed++;
  endtask

  task automatic wr_byte(logic cd, logic [7:0] v);
    @(negedge clk);
    bus.direction = 1'b0;
    drv_en  = 1'b1;
    drv_val = v;
    bus.CD  = cd;
    repeat (4) @(negedge clk);
    bus.WR = 1'b1;
    repeat (4) @(negedge clk);
    bus.WR = 1'b0;
    repeat (4) @(negedge clk);
    drv_en = 1'b0;
    bus.direction = 1'b1;
  endtask

  task automatic do_exec();
    @(negedge clk);
    bus.excute = 1'b1;
    repeat (4) @(negedge clk);
    bus.excute = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Samples the current byte, then pulses RD to step the pointer.
  task automatic rd_byte(input bit use_lcd, output logic [7:0] v);
    @(negedge clk);
    v = use_lcd ? bus.LCD_data : pico_data;
    bus.RD = 1'b0;
    repeat (4) @(negedge clk);
    bus.RD = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  logic [7:0] got;
  logic [7:0] e;

  initial begin
    bus.CS = 1'b0; bus.WR = 1'b0; bus.RD = 1'b1; bus.CD = 1'b0;
    bus.excute = 1'b0; bus.sel_poc = 1'b0; bus.sel_sod = 1'b1;
    bus.direction = 1'b1; bus.cam_data = 8'h00;

    // ---- reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_pico_hiz", pico_data, 8'hFF);
    check("rst_lcd_sod1", bus.LCD_data, 8'h00);
    bus.sel_sod = 1'b0;
    @(negedge clk);
    check("rst_lcd_sod0", bus.LCD_data, 8'h00);
    bus.sel_sod = 1'b1;

    // ---- CS=0: strobes ignored, bus released
    wr_byte(1'b1, 8'hFF);
    wr_byte(1'b0, 8'h33);
    rd_byte(1'b0, got);
    check("cs0_pico_hiz", got, 8'hFF);
    bus.CS = 1'b1;
    do_exec();
    for (int k = 0; k < 4; k++) begin
      rd_byte(1'b0, got);
      check($sformatf("cs0_byte%0d", k), got, 8'h00);
    end

    // ---- table: mode 1 with boundary lane 31, wrap, then mode 0
    add(T_WA, 8'h40); add(T_WD, 8'h01);
    add(T_WA, 8'h00); add(T_WD, 8'h02);
    add(T_WA, 8'h01); add(T_WD, 8'h03);
    add(T_WA, 8'h02); add(T_WD, 8'h04);
    add(T_WA, 8'h20); add(T_WD, 8'h05);
    add(T_WA, 8'h21); add(T_WD, 8'h06);
    add(T_WA, 8'h22); add(T_WD, 8'h07);
    add(T_WA, 8'h1F); add(T_WD, 8'h03);
    add(T_WA, 8'h3F); add(T_WD, 8'h02);
    add(T_EX, 8'h00);
    for (int k = 0; k < 64; k++) begin
      e = (k == 0)  ? 8'h0A :
          (k == 2)  ? 8'h12 :
          (k == 4)  ? 8'h1C :
          (k == 62) ? 8'h06 : 8'h00;
      add(T_RD, e);
    end
    add(T_RD, 8'h0A);                       // 65th read wraps to byte 0
    add(T_WA, 8'h40); add(T_WD, 8'h00);
    add(T_EX, 8'h00);
    add(T_RD, 8'h07); add(T_RD, 8'h00);
    add(T_RD, 8'h09); add(T_RD, 8'h00);
    add(T_RD, 8'h0B); add(T_RD, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        T_WA: wr_byte(1'b1, vecs[i].val);
        T_WD: wr_byte(1'b0, vecs[i].val);
        T_EX: do_exec();
        default: begin
          rd_byte(1'b0, got);
          check($sformatf("vec%0d", i), got, vecs[i].val);
        end
      endcase
    end

    // ---- multiply-accumulate from a cleared result bank
    do_reset();
    wr_byte(1'b1, 8'h40); wr_byte(1'b0, 8'h02);
    wr_byte(1'b1, 8'h00); wr_byte(1'b0, 8'hFF);
    wr_byte(1'b1, 8'h20); wr_byte(1'b0, 8'hFF);
    do_exec();
    rd_byte(1'b0, got); check("mac1_lo", got, 8'h01);
    rd_byte(1'b0, got); check("mac1_hi", got, 8'hFE);
    do_exec();
`ifdef SIMD_SAT_EN
    rd_byte(1'b0, got); check("mac2_lo", got, 8'hFF);
    rd_byte(1'b0, got); check("mac2_hi", got, 8'hFF);
`else
    rd_byte(1'b0, got); check("mac2_lo", got, 8'h02);
    rd_byte(1'b0, got); check("mac2_hi", got, 8'hFC);
`endif

    // ---- camera write source, then mode 1: R[0] = 09*FF = 08F7
    wr_byte(1'b1, 8'h00);
    bus.sel_poc = 1'b1;
    bus.cam_data = 8'h09;
    wr_byte(1'b0, 8'h55);
    bus.sel_poc = 1'b0;
    wr_byte(1'b1, 8'h40); wr_byte(1'b0, 8'h01);
    do_exec();
    check("cam_pico", pico_data, 8'hF7);
    check("sod1_lcd_zero", bus.LCD_data, 8'h00);

    // ---- LCD routing
    bus.sel_sod = 1'b0;
    @(negedge clk);
    check("sod0_pico_hiz", pico_data, 8'hFF);
    rd_byte(1'b1, got); check("lcd_byte0", got, 8'hF7);
    check("lcd_byte1", bus.LCD_data, 8'h08);

    // ---- direction=0 releases the bus
    bus.sel_sod = 1'b1;
    bus.direction = 1'b0;
    @(negedge clk);
    check("dir0_pico_hiz", pico_data, 8'hFF);
    bus.direction = 1'b1;
    @(negedge clk);
    check("dir1_pico", pico_data, 8'h08);

    // ---- asynchronous reset between RD pulses
    bus.sel_sod = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst_lcd", bus.LCD_data, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.sel_sod = 1'b1;
    repeat (2) @(negedge clk);
    rd_byte(1'b0, got); check("post_rst_byte0", got, 8'h00);
    rd_byte(1'b0, got); check("post_rst_byte1", got, 8'h00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/simd_pico_top.md
Name: simd_pico_top

Overview:
- Byte-wide SIMD co-processor that sits on the Pico 8-bit parallel bus.
- The host writes an address byte, then a data byte, to load operand banks A and B and a mode register.
- A pulse on `excute` computes every lane in parallel into a 16-bit result bank.
- The host streams results back byte by byte over the bidirectional bus, or to the LCD port.
- Optional camera bytes can replace host data as the write source.

Parameters:
- LANES, 32: number of SIMD lanes. Also the size of banks A, B and R. Maximum 32.
- B_BASE, 32: address of B[0].
- MODE_ADDR, 64: address of the mode register.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- CS, in, 1: chip select, active-high. While low, every strobe is ignored and pico_data is hi-Z.
- WR, in, 1: write strobe. Asynchronous to clk; acts on its rising edge.
- RD, in, 1: read strobe. Asynchronous; acts on its falling edge.
- CD, in, 1: 1 = the written byte is an address, 0 = the written byte is data.
- excute, in, 1: start-compute strobe. Asynchronous; acts on its rising edge.
- sel_poc, in, 1: write-data source. 0 = pico_data, 1 = cam_data.
- sel_sod, in, 1: read-data destination. 1 = pico_data, 0 = LCD_data.
- direction, in, 1: 1 = the block drives pico_data (host reads). 0 = the host drives it.
- pico_data, inout, 8: host data bus.
- cam_data, in, 8: camera pixel byte.
- LCD_data, out, 8: result byte routed to the LCD.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Synchronisation:
  - WR, RD and excute each pass through a 2-flop synchroniser followed by an edge detector.
  - Each edge yields a one-cycle event 3 clk after the pin edge.
  - Strobe high and low times are at least 3 clk.
- Write event (CS=1 at the event):
  - wdata = sel_poc ? cam_data : pico_data, sampled from the synchronised copy.
  - CD=1: addr_reg <= wdata[6:0]; rd_ptr <= 0.
  - CD=0: decode addr_reg.
    - 0..LANES-1: A[addr] <= wdata.
    - B_BASE..B_BASE+LANES-1: B[addr-B_BASE] <= wdata.
    - MODE_ADDR: mode <= wdata[1:0].
    - Any other address: write ignored.
  - addr_reg does not auto-increment.
- Execute event (CS is ignored):
  - All lanes update together in one clk. Results are valid the cycle after the event.
  - mode 0: R[i] = A[i] + B[i].
  - mode 1: R[i] = A[i] * B[i].
  - mode 2: R[i] = A[i] * B[i] + R[i]old, accumulating, wrapping mod 2^16.
  - mode 3: R is unchanged.
  - rd_ptr <= 0 on every execute event.
- Read path:
  - rd_ptr is 6 bits; byte index k = rd_ptr.
  - rbyte = k[0] ? R[k>>1][15:8] : R[k>>1][7:0], i.e. low byte first.
  - A synchronised RD falling edge with CS=1 increments rd_ptr. The pointer wraps from 2*LANES-1 to 0.
- Output drivers:
  - pico_data is driven with rbyte when CS & direction & sel_sod; otherwise it is hi-Z.
  - LCD_data = (sel_sod==0) ? rbyte : 8'h00.
- Reset values:
  - A, B and R are all 0.
  - mode = 0, addr_reg = 0, rd_ptr = 0.
  - LCD_data = 0 and pico_data is hi-Z.
- Simultaneous events:
  - Execute and write in the same clk: the write is applied first, and execute uses the new operands.
  - Execute and RD in the same clk: execute wins and rd_ptr becomes 0.
  - Reset mid-operation clears everything immediately.

Optional Feature:
- Macro SIMD_SAT_EN.
- When defined, mode 2 saturates at 16'hFFFF instead of wrapping.
- Modes 0 and 1 cannot overflow 16 bits and are unaffected.
- When the macro is absent, mode 2 wraps mod 2^16.

Decomposition:
- Package simd_pico_pkg holds:
  - MODE_ADD=0, MODE_MUL=1, MODE_MAC=2, MODE_NOP=3;
  - a mode_t typedef;
  - the B_BASE and MODE_ADDR constants.
- Sub-module simd_lane: combinational; inputs a[7:0], b[7:0], acc[15:0] and mode; output r[15:0]. The top instantiates LANES copies via generate.

Test Plan:
- Reset with CS=0, then a WR with CD=1, pico_data=FF, followed by reads → the write is ignored and every result byte reads 00.
- CS=1; write mode=1, A[0..2]=2,3,4, B[0..2]=5,6,7; excute; direction=1, sel_sod=1; 64 RD pulses → bytes 0A,00,12,00,1C,00,00 and so on; the 65th read returns 0A (wrap).
- Same operands with mode=0 → reads 07,00,09,00,0B,00.
- mode=2, A[0]=FF, B[0]=FF, excute twice → R[0]=FE01, then FC02 (wrap), or FFFF with SIMD_SAT_EN.
- sel_sod=0 → pico_data is hi-Z and LCD_data follows rbyte as RD pulses; sel_poc=1 with cam_data=09 and a data write to A[0] → A[0]=09.
- Assert rst_n low between RD pulses → rd_ptr, R and LCD_data return to 0 asynchronously.
